// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for fetch and load/store requesters
//   i_clk, i_reset              clock, synchronous active-high reset
//   if_req/if_addr/if_flush     fetch request, word address, redirect
//   ls_req/ls_wren/ls_addr/ls_wdata/ls_bmask  load/store request and fields
//   mem_ack/mem_rdata           memory completion pulse and read data
//   mem_req/mem_wren/mem_addr/mem_wdata/mem_bmask  registered memory transaction
//   if_valid/if_rdata, ls_valid/ls_rdata  completion pulses and held data
//   if_stall, ls_stall          request pending and not yet completed
//   o_timeout                   sticky: memory failed to answer within 255 cycles
module mem_arbiter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    input  logic        ls_req,
    input  logic        ls_wren,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_bmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_wren,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_bmask,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        if_stall,
    output logic        ls_stall,
    output logic        o_timeout
);
    typedef enum logic [1:0] {IDLE, LS_WAIT, IF_WAIT, IF_DROP} state_t;
    state_t     state;
    logic [7:0] wait_cnt;
    // A request whose valid pulse is showing is already served, so the stall
    // terms double as the grant qualifiers and prevent a duplicate grant.
    assign if_stall = if_req && !if_valid;
    assign ls_stall = ls_req && !ls_valid;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_wren  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_bmask <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            ls_valid  <= 1'b0;
            ls_rdata  <= '0;
            o_timeout <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            if (state == IDLE) begin
                wait_cnt <= '0;
                if (ls_stall) begin
                    state     <= LS_WAIT;
                    mem_req   <= 1'b1;
                    mem_wren  <= ls_wren;
                    mem_addr  <= ls_addr;
                    mem_wdata <= ls_wdata;
                    mem_bmask <= ls_bmask;
                end else if (if_stall && !if_flush) begin
                    state     <= IF_WAIT;
                    mem_req   <= 1'b1;
                    mem_wren  <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    mem_bmask <= '0;
                end
            end else if (mem_ack) begin
                state   <= IDLE;
                mem_req <= 1'b0;
                if (state == LS_WAIT) begin
                    ls_valid <= 1'b1;
                    ls_rdata <= mem_rdata;
                end
                if (state == IF_WAIT && !if_flush) begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
                // The counter reaches 255 at this edge: abandon the transaction.
                if (wait_cnt == 8'd254) begin
                    state     <= IDLE;
                    mem_req   <= 1'b0;
                    o_timeout <= 1'b1;
                end else if (state == IF_WAIT && if_flush) begin
                    state <= IF_DROP;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transaction checks for mem_arbiter
module tb_mem_arbiter;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        if_req, if_flush, ls_req, ls_wren, mem_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_bmask;
    logic        mem_req, mem_wren, if_valid, ls_valid, if_stall, ls_stall, o_timeout;
    logic [31:0] mem_addr, mem_wdata, if_rdata, ls_rdata;
    logic [3:0]  mem_bmask;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_ls, last_if;
    logic        exp_tmo;

    mem_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .ls_req(ls_req), .ls_wren(ls_wren), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_bmask(ls_bmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_bmask(mem_bmask),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .if_stall(if_stall), .ls_stall(ls_stall), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Completion pulses are mutually exclusive in every cycle.
    always @(negedge i_clk)
        if (i_reset === 1'b0) chk1("valid_excl", if_valid && ls_valid, 1'b0);

    // Load/store: grant this cycle, ack after lat cycles, valid the cycle after.
    task automatic do_ls(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] bm, input int lat, input logic [31:0] rd);
        ls_req = 1'b1; ls_wren = wr; ls_addr = a; ls_wdata = d; ls_bmask = bm;
        #1;
        chk1("ls_stall_grant", ls_stall, 1'b1);
        chk1("ls_mem_req_pre", mem_req, 1'b0);
        cyc();
        ls_addr = $urandom; ls_wdata = $urandom; ls_bmask = 4'($urandom); ls_wren = ~wr;
        for (int k = 1; k <= lat; k++) begin
            mem_ack = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            #1;
            chk1("ls_mem_req", mem_req, 1'b1);
            chk1("ls_mem_wren", mem_wren, wr);
            chk32("ls_mem_addr", mem_addr, a);
            chk32("ls_mem_wdata", mem_wdata, d);
            chk32("ls_mem_bmask", {28'd0, mem_bmask}, {28'd0, bm});
            chk1("ls_stall_wait", ls_stall, 1'b1);
            chk1("ls_valid_wait", ls_valid, 1'b0);
            cyc();
        end
        mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        chk1("ls_valid", ls_valid, 1'b1);
        chk32("ls_rdata", ls_rdata, rd);
        chk1("ls_if_valid", if_valid, 1'b0);
        chk1("ls_mem_req_done", mem_req, 1'b0);
        chk1("ls_stall_done", ls_stall, 1'b0);
        chk1("ls_timeout", o_timeout, exp_tmo);
        last_ls = rd;
        ls_req = 1'b0;
        cyc();
        chk1("ls_valid_once", ls_valid, 1'b0);
        chk32("ls_rdata_hold", ls_rdata, last_ls);
        chk1("ls_no_regrant", mem_req, 1'b0);
    endtask

    // Fetch with optional one-cycle flush at wait cycle flush_at (0 = none).
    task automatic do_if(input logic [31:0] a, input int lat, input logic [31:0] rd,
                         input int flush_at);
        logic exp_v;
        if_req = 1'b1; if_addr = a; if_flush = 1'b0;
        #1;
        chk1("if_stall_grant", if_stall, 1'b1);
        cyc();
        if_addr = $urandom;
        for (int k = 1; k <= lat; k++) begin
            if_flush = (k == flush_at);
            if (k == flush_at) if_req = 1'b0;
            mem_ack = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            #1;
            chk1("if_mem_req", mem_req, 1'b1);
            chk1("if_mem_wren", mem_wren, 1'b0);
            chk32("if_mem_addr", mem_addr, a);
            chk32("if_mem_bmask", {28'd0, mem_bmask}, 32'd0);
            chk1("if_valid_wait", if_valid, 1'b0);
            cyc();
        end
        if_flush = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        exp_v = (flush_at == 0);
        if (exp_v) last_if = rd;
        chk1("if_valid", if_valid, exp_v);
        chk32("if_rdata", if_rdata, last_if);
        chk1("if_mem_req_done", mem_req, 1'b0);
        chk1("if_ls_valid", ls_valid, 1'b0);
        if_req = 1'b0;
        cyc();
        chk1("if_valid_once", if_valid, 1'b0);
        chk32("if_rdata_hold", if_rdata, last_if);
        chk1("if_no_regrant", mem_req, 1'b0);
    endtask

    initial begin
        int n;
        int lat;
        logic [31:0] a;
        i_reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req = 1'b0; ls_wren = 1'b0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        last_ls = '0; last_if = '0; exp_tmo = 1'b0;
        cyc();
        cyc();
        i_reset = 1'b0;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_ls_valid", ls_valid, 1'b0);
        chk32("rst_ls_rdata", ls_rdata, 32'd0);
        chk1("rst_timeout", o_timeout, 1'b0);

        do_ls(1'b0, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF);
        do_ls(1'b1, 32'h200, 32'hCAFEF00D, 4'hA, 1, 32'h12345678);
        do_if(32'h40, 1, 32'hA5A5A5A5, 0);
        do_if(32'h44, 3, 32'h11111111, 1);
        do_if(32'h48, 2, 32'h22222222, 2);

        // Fetch request during a redirect is not granted.
        if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h80;
        cyc();
        chk1("flush_idle_no_grant", mem_req, 1'b0);
        if_req = 1'b0; if_flush = 1'b0;

        // Stray ack in IDLE.
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        cyc();
        mem_ack = 1'b0;
        chk1("stray_ls_valid", ls_valid, 1'b0);
        chk1("stray_if_valid", if_valid, 1'b0);
        chk1("stray_mem_req", mem_req, 1'b0);

        // Contention: load/store first, fetch granted in the completion cycle.
        ls_req = 1'b1; ls_wren = 1'b0; ls_addr = 32'h300; ls_wdata = '0; ls_bmask = '0;
        if_req = 1'b1; if_addr = 32'h50;
        #1;
        chk1("cont_if_stall0", if_stall, 1'b1);
        cyc();
        chk32("cont_ls_first", mem_addr, 32'h300);
        chk1("cont_if_stall1", if_stall, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h33333333;
        cyc();
        mem_ack = 1'b0;
        chk1("cont_ls_valid", ls_valid, 1'b1);
        chk1("cont_if_stall2", if_stall, 1'b1);
        last_ls = 32'h33333333;
        ls_req = 1'b0;
        cyc();
        chk1("cont_if_grant", mem_req, 1'b1);
        chk32("cont_if_addr", mem_addr, 32'h50);
        chk1("cont_if_stall3", if_stall, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h44444444;
        cyc();
        mem_ack = 1'b0;
        chk1("cont_if_valid", if_valid, 1'b1);
        chk32("cont_if_rdata", if_rdata, 32'h44444444);
        chk1("cont_if_stall4", if_stall, 1'b0);
        last_if = 32'h44444444;
        if_req = 1'b0;
        cyc();

        // Randomized transactions with stray acks in the gaps.
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
                mem_ack = 1'($urandom); mem_rdata = $urandom;
                cyc();
                chk1("rnd_gap_ls_valid", ls_valid, 1'b0);
                chk1("rnd_gap_if_valid", if_valid, 1'b0);
                chk1("rnd_gap_mem_req", mem_req, 1'b0);
            end
            mem_ack = 1'b0;
            lat = $urandom_range(1, 5);
            a = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_ls(1'($urandom), a, $urandom, 4'($urandom), lat, $urandom);
            else
                do_if(a, lat, $urandom,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lat)) : 0);
        end

        // Timeout: memory never answers.
        if_req = 1'b1; if_addr = 32'h90;
        cyc();
        n = 0;
        while (mem_req === 1'b1 && n < 400) begin
            n++;
            cyc();
            if (if_valid === 1'b1) chk1("tmo_if_valid", if_valid, 1'b0);
        end
        if_req = 1'b0;
        chk32("tmo_len", 32'(n), 32'd255);
        chk1("tmo_flag", o_timeout, 1'b1);
        chk1("tmo_no_valid", if_valid, 1'b0);
        exp_tmo = 1'b1;
        cyc();
        chk1("tmo_no_regrant", mem_req, 1'b0);
        do_ls(1'b0, 32'h400, 32'h0, 4'h0, 2, 32'h55555555);
        chk1("tmo_sticky", o_timeout, 1'b1);

        // Reset in the middle of a load, then the memory's late ack.
        ls_req = 1'b1; ls_wren = 1'b1; ls_addr = 32'h500; ls_wdata = 32'h66666666; ls_bmask = 4'hF;
        cyc();
        cyc();
        chk1("mid_mem_req", mem_req, 1'b1);
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0; ls_req = 1'b0;
        exp_tmo = 1'b0; last_ls = '0; last_if = '0;
        chk1("mrst_mem_req", mem_req, 1'b0);
        chk1("mrst_mem_wren", mem_wren, 1'b0);
        chk32("mrst_mem_addr", mem_addr, 32'd0);
        chk32("mrst_mem_wdata", mem_wdata, 32'd0);
        chk32("mrst_mem_bmask", {28'd0, mem_bmask}, 32'd0);
        chk32("mrst_ls_rdata", ls_rdata, 32'd0);
        chk32("mrst_if_rdata", if_rdata, 32'd0);
        chk1("mrst_timeout", o_timeout, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        cyc();
        mem_ack = 1'b0;
        chk1("mrst_stray_ls_valid", ls_valid, 1'b0);
        chk32("mrst_stray_ls_rdata", ls_rdata, 32'd0);
        chk1("mrst_stray_mem_req", mem_req, 1'b0);
        do_ls(1'b0, 32'h600, 32'h0, 4'h0, 1, 32'h88888888);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  32  fetch word address.
- if_flush  in  1  redirect; any outstanding fetch is discarded.
- ls_req  in  1  load/store request; held until ls_valid.
- ls_wren  in  1  1 = store, 0 = load.
- ls_addr  in  32  data address.
- ls_wdata  in  32  store data.
- ls_bmask  in  4  store byte enables.
- mem_ack  in  1  memory completion, 1-cycle pulse.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_req  out  1  memory request, held until mem_ack.
- mem_wren, mem_addr, mem_wdata, mem_bmask  out  1/32/32/4  registered transaction fields.
- if_valid, if_rdata  out  1/32  fetch completion pulse and data.
- ls_valid, ls_rdata  out  1/32  load/store completion pulse and data.
- if_stall  out  1  if_req && !if_valid; gates pc_wren and IFID_wren.
- ls_stall  out  1  ls_req && !ls_valid; freezes the full pipeline.
- o_timeout  out  1  sticky flag: memory failed to respond.
REQ-003 Requester fields SHALL be sampled only in the grant cycle; changes after grant SHALL have no effect.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, LS_WAIT, IF_WAIT and IF_DROP.
REQ-005 In IDLE, ls_req SHALL have strict priority: ls_req=1 SHALL capture the ls fields and go to LS_WAIT. Otherwise, if_req=1 with if_flush=0 SHALL capture if_addr with wren=0 and bmask=0 and go to IF_WAIT.
REQ-006 mem_req and the mem fields SHALL be registered: a grant in cycle N SHALL drive mem_req=1 from cycle N+1 until the cycle mem_ack is sampled high, inclusive.
REQ-007 In LS_WAIT, mem_ack=1 SHALL pulse ls_valid for one cycle with ls_rdata=mem_rdata at the next edge, and SHALL return the FSM to IDLE.
REQ-008 In IF_WAIT, mem_ack=1 with if_flush=0 SHALL pulse if_valid with if_rdata=mem_rdata at the next edge and SHALL return the FSM to IDLE.
REQ-009 In IF_WAIT, if_flush=1 without mem_ack SHALL move the FSM to IF_DROP.
REQ-010 In IF_WAIT, if_flush=1 together with mem_ack SHALL return the FSM to IDLE with no if_valid pulse.
REQ-011 In IF_DROP, mem_req SHALL stay high until mem_ack; the FSM SHALL then go to IDLE and no if_valid SHALL be generated.
REQ-012 Minimum round trip SHALL be 2 cycles: grant at N, ack at N+1, valid at N+2.
REQ-013 The block SHALL perform no back-to-back grant: the IDLE cycle after a completion SHALL be the earliest next grant.
REQ-014 An if_req pending in IDLE while ls_req=1 SHALL wait, with if_stall held high.
REQ-015 mem_ack sampled in IDLE SHALL be ignored: no valid pulse and no state change.
REQ-016 if_valid and ls_valid SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per grant.
REQ-017 if_rdata and ls_rdata SHALL hold their last value between valid pulses.
REQ-018 An 8-bit wait counter SHALL clear on each grant and increment every cycle in any WAIT or DROP state without mem_ack.
REQ-019 When the counter reaches 255, the FSM SHALL abort to IDLE, drop mem_req, set o_timeout, and generate no valid pulse; the requester then re-arbitrates.
REQ-020 o_timeout SHALL clear only on reset.
REQ-021 if_stall and ls_stall SHALL be combinational from the requests and the current valid outputs.

Reset
REQ-022 i_reset=1 at a rising edge SHALL force state=IDLE, counter=0, and set mem_req, mem_wren, mem_addr, mem_wdata, mem_bmask, if_valid, if_rdata, ls_valid, ls_rdata and o_timeout to 0.
REQ-023 Reset mid-transaction SHALL drop mem_req at that edge; a later mem_ack for the aborted transaction SHALL be ignored per REQ-015.
REQ-024 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Load, ack after 3 cycles: ls_req=1, ls_addr=0x100, grant at N, mem_ack at N+3 with rdata=0xDEADBEEF -> ls_valid=1 and ls_rdata=0xDEADBEEF at N+4; ls_stall=1 from N to N+3.
- Contention: if_req and ls_req both high in IDLE -> ls transaction served first; fetch granted in the IDLE cycle after ls_valid; if_stall high throughout.
- Flush mid-fetch: if_flush=1 one cycle after fetch grant, ack two cycles later -> state IF_DROP, no if_valid, IDLE after ack.
- Flush with ack in the same cycle: flush and mem_ack coincide in IF_WAIT -> no if_valid, IDLE next cycle.
- Timeout: grant, mem_ack held low -> at 255 wait cycles mem_req=0, o_timeout=1, no valid; o_timeout stays 1 until reset.
- Reset mid-load, then a stray mem_ack -> all outputs 0 after the reset edge; the stray ack causes no valid pulse.
